m_stage_dm_ctrl: RTL

- Memory-stage data-memory controller; the consumer end of the E/M pipeline register.
- Takes IMcode_M/PC_M/AO_M/RT_M, decodes loads/stores, and drives a req/ack data-memory bus: byte enables, store-lane replication, load extraction and extension.
- Stalls the pipeline until the access completes.
- Non-memory instructions pass with zero latency.

---
 rtl/mips_defs.sv | 31 +++
 rtl/dm_lane_ext.sv | 37 +++
 rtl/m_stage_dm_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcodes, memory-stage FSM encoding and reset PC.
`timescale 1ns/1ps
package mips_defs;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } dm_state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Combinational load lane extraction and sign/zero extension; shared with the W stage.
`timescale 1ns/1ps
module dm_lane_ext
  import mips_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  logic [5:0]  op,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (a)
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      2'd3:    lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    lane_h = a[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = word;
    case (op)
      OP_LB:   result = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  result = {24'd0, lane_b};
      OP_LH:   result = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  result = {16'd0, lane_h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/m_stage_dm_ctrl.sv
// M-stage data-memory controller: req/ack bus master with stall, lane handling and ack timeout.
// Build option DM_ALIGN_EXC_EN: misaligned half/word accesses raise exc_adel/exc_ades instead of a bus access.
`timescale 1ns/1ps
module m_stage_dm_ctrl
  import mips_defs::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] IMcode_M,
  input  logic [31:0] PC_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] RT_M,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        Stall_M,
  output logic [31:0] RD_M,
  output logic        bus_err,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] EPC_M,
  output logic [1:0]  dbg_state
);

  // Handshake: dm_req stays high from the IDLE->REQ edge until the edge on which
  // dm_ack=1 is sampled (or the timeout fires); bus fields are frozen meanwhile.

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  dm_state_t       state, state_n;
  logic [TO_W-1:0] to_cnt;
  logic [5:0]      op;
  logic [1:0]      a;
  logic            ld, st, mem_op, misal, to_hit;
  logic [3:0]      be_n;
  logic [31:0]     wdata_n, ext_word;
  logic            unused_imm;

  assign op         = IMcode_M[31:26];
  assign a          = AO_M[1:0];
  assign ld         = is_load(op);
  assign st         = is_store(op);
  assign mem_op     = ld | st;
  assign unused_imm = ^IMcode_M[25:0];
  assign to_hit     = (to_cnt == TO_LAST);

`ifdef DM_ALIGN_EXC_EN
  assign misal = (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && a[0]) ||
                 (((op == OP_LW) || (op == OP_SW)) && (a != 2'd0));
`else
  assign misal = 1'b0;
`endif

  assign dm_req    = (state == ST_REQ);
  assign Stall_M   = Reset && mem_op && (state != ST_DONE);
  assign dbg_state = state;

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = RT_M;
    case (op)
      OP_SB: begin
        be_n    = 4'b0001 << a;
        wdata_n = {4{RT_M[7:0]}};
      end
      OP_SH: begin
        be_n    = a[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{RT_M[15:0]}};
      end
      default: ;
    endcase
  end

  dm_lane_ext u_lane_ext (
    .word   (dm_rdata),
    .a      (a),
    .op     (op),
    .result (ext_word)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (mem_op) state_n = misal ? ST_DONE : ST_REQ;
      ST_REQ:  if (dm_ack || to_hit) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      to_cnt   <= '0;
      dm_we    <= 1'b0;
      dm_addr  <= 32'd0;
      dm_be    <= 4'd0;
      dm_wdata <= 32'd0;
      RD_M     <= 32'd0;
      bus_err  <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      EPC_M    <= RESET_PC;
    end else begin
      state    <= state_n;
      bus_err  <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_op && misal) begin
            exc_adel <= ld;
            exc_ades <= st;
            EPC_M    <= PC_M;
            RD_M     <= 32'd0;
          end else if (mem_op) begin
            dm_we    <= st;
            dm_addr  <= {AO_M[31:2], 2'b00};
            dm_be    <= be_n;
            dm_wdata <= wdata_n;
            to_cnt   <= '0;
          end
        end
        ST_REQ: begin
          // An ack on the timeout cycle takes priority over the error.
          if (dm_ack) begin
            if (!dm_we) RD_M <= ext_word;
          end else if (to_hit) begin
            bus_err <= 1'b1;
            RD_M    <= 32'd0;
            EPC_M   <= PC_M;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
